// File: rtl/hr_dma_arbiter.sv
// hr_dma_arbiter
//   Shares the banked high-RAM window (four 8-bit SRAMs, chip chosen by
//   bank[7:6], page by bank[5:0], 13-bit offset) between the 65C02 and a DMA
//   requester. The CPU is halted through RDY at a bus-cycle boundary. The bus
//   is then taken and timed SRAM cycles are run for the requester. Bursts are
//   capped so the CPU always gets a bus cycle between two grants.
//
// Ports
//   clk, rst            clock, synchronous active-low reset
//   cyc_end             strobe on the last clock of every CPU bus cycle
//   cpu_bank            CPU bank register (page bits used while CPU owns bus)
//   dma_req/we/bank/addr/wdata   request; held until dma_ack
//   dma_gnt, dma_ack, dma_rdata  grant, completion pulse, read data
//   cpu_rdy, bus_dma    CPU RDY, bus ownership (1 = DMA drives bus)
//   hr_adr, hr_dout, hr_din, hr_cs_n, hr_we_n, hr_oe_n, rbank   SRAM side
module hr_dma_arbiter #(
  parameter int ACC_CYCLES = 3,
  parameter int MAX_BURST  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cyc_end,
  input  logic [7:0]  cpu_bank,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [7:0]  dma_bank,
  input  logic [12:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic        dma_gnt,
  output logic        dma_ack,
  output logic [7:0]  dma_rdata,
  output logic        cpu_rdy,
  output logic        bus_dma,
  output logic [12:0] hr_adr,
  output logic [7:0]  hr_dout,
  input  logic [7:0]  hr_din,
  output logic [3:0]  hr_cs_n,
  output logic        hr_we_n,
  output logic        hr_oe_n,
  output logic [5:0]  rbank
);

  localparam int ACC_W   = $clog2(ACC_CYCLES + 1);
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam logic [ACC_W-1:0]   ACC_LAST   = ACC_W'(ACC_CYCLES - 1);
  // Last access clock on which the write strobe is still low.
  localparam logic [ACC_W-1:0]   WE_LAST    = ACC_W'(ACC_CYCLES - 2);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    TURN,
    ACCESS,
    ACK,
    RELEASE
  } state_t;

  state_t               state;
  logic [ACC_W-1:0]     accCnt;
  logic [BURST_W-1:0]   burstCnt;
  logic                 holdoff;
  logic                 limitHit;
  logic                 reqLat;
  logic [7:0]           bankLat;
  logic [12:0]          addrLat;
  logic                 weLat;
  logic [7:0]           wdataLat;
  logic                 burstMore;
  logic                 latchEn;
  logic                 unusedCpuBankHi;

  function automatic logic [3:0] csDecode(input logic [1:0] sel);
    csDecode = ~(4'b0001 << sel);
  endfunction

  // Another access fits in this grant only if a request is pending and the
  // burst cap has not been reached.
  assign burstMore = dma_req && (burstCnt != BURST_LAST);
  assign latchEn   = ((state == HALT) && cyc_end) || ((state == ACK) && burstMore);

  // Request fields are captured when the bus is taken and at each chained ack.
  always_ff @(posedge clk) begin
    if (latchEn) begin
      bankLat  <= dma_bank;
      addrLat  <= dma_addr;
      weLat    <= dma_we;
      wdataLat <= dma_wdata;
    end
  end

  assign hr_adr  = addrLat;
  assign hr_dout = wdataLat;
  assign rbank   = bus_dma ? bankLat[5:0] : cpu_bank[5:0];
  assign unusedCpuBankHi = ^cpu_bank[7:6];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cpu_rdy   <= 1'b1;
      bus_dma   <= 1'b0;
      dma_gnt   <= 1'b0;
      dma_ack   <= 1'b0;
      dma_rdata <= '0;
      hr_cs_n   <= 4'hF;
      hr_we_n   <= 1'b1;
      hr_oe_n   <= 1'b1;
      accCnt    <= '0;
      burstCnt  <= '0;
      holdoff   <= 1'b0;
      limitHit  <= 1'b0;
      reqLat    <= 1'b0;
    end else begin
      dma_ack <= 1'b0;
      if (cyc_end) holdoff <= 1'b0;
      case (state)
        IDLE: begin
          if (dma_req && !holdoff) begin
            state   <= HALT;
            cpu_rdy <= 1'b0;
          end
        end
        HALT: begin
          if (cyc_end) begin
            state    <= TURN;
            bus_dma  <= 1'b1;
            dma_gnt  <= 1'b1;
            burstCnt <= '0;
            reqLat   <= dma_req;
          end
        end
        TURN: begin
          // A request withdrawn during HALT still costs the turnaround but
          // hands the bus straight back without an access.
          if (reqLat) begin
            state   <= ACCESS;
            accCnt  <= '0;
            hr_cs_n <= csDecode(bankLat[7:6]);
            hr_we_n <= !weLat;
            hr_oe_n <= weLat;
          end else begin
            state    <= RELEASE;
            bus_dma  <= 1'b0;
            dma_gnt  <= 1'b0;
            limitHit <= 1'b0;
          end
        end
        ACCESS: begin
          if (accCnt == ACC_LAST) begin
            state   <= ACK;
            accCnt  <= '0;
            hr_cs_n <= 4'hF;
            hr_we_n <= 1'b1;
            hr_oe_n <= 1'b1;
            dma_ack <= 1'b1;
            if (!weLat) dma_rdata <= hr_din;
          end else begin
            accCnt <= accCnt + 1'b1;
            // Write strobe rises one clock early so address/data hold past it.
            if (accCnt == WE_LAST) hr_we_n <= 1'b1;
          end
        end
        ACK: begin
          burstCnt <= burstCnt + 1'b1;
          if (burstMore) begin
            state   <= ACCESS;
            accCnt  <= '0;
            hr_cs_n <= csDecode(dma_bank[7:6]);
            hr_we_n <= !dma_we;
            hr_oe_n <= dma_we;
          end else begin
            state    <= RELEASE;
            bus_dma  <= 1'b0;
            dma_gnt  <= 1'b0;
            // A request still pending here means the cap ended the burst.
            limitHit <= dma_req;
          end
        end
        RELEASE: begin
          state   <= IDLE;
          cpu_rdy <= 1'b1;
          if (limitHit) holdoff <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hr_dma_arbiter.sv
module tb_hr_dma_arbiter;
  localparam int ACC = 3;
  localparam int MB  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc_end;
  logic [7:0]  cpu_bank;
  logic        dma_req;
  logic        dma_we;
  logic [7:0]  dma_bank;
  logic [12:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_gnt;
  logic        dma_ack;
  logic [7:0]  dma_rdata;
  logic        cpu_rdy;
  logic        bus_dma;
  logic [12:0] hr_adr;
  logic [7:0]  hr_dout;
  logic [7:0]  hr_din;
  logic [3:0]  hr_cs_n;
  logic        hr_we_n;
  logic        hr_oe_n;
  logic [5:0]  rbank;

  int errors = 0;
  int checks = 0;
  int viol = 0;

  typedef struct {
    logic        we;
    logic [7:0]  bank;
    logic [12:0] addr;
    logic [7:0]  data;
  } req_t;

  req_t q[$];
  req_t wr[$];
  logic [7:0] sram [int];
  logic [7:0] refMem [int];

  always #5 clk = ~clk;

  hr_dma_arbiter #(.ACC_CYCLES(ACC), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .cyc_end(cyc_end), .cpu_bank(cpu_bank),
    .dma_req(dma_req), .dma_we(dma_we), .dma_bank(dma_bank),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_gnt(dma_gnt),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata), .cpu_rdy(cpu_rdy),
    .bus_dma(bus_dma), .hr_adr(hr_adr), .hr_dout(hr_dout), .hr_din(hr_din),
    .hr_cs_n(hr_cs_n), .hr_we_n(hr_we_n), .hr_oe_n(hr_oe_n), .rbank(rbank)
  );

  function automatic int keyOf(input int chip, input logic [5:0] page, input logic [12:0] off);
    return (chip << 19) | (int'(page) << 13) | int'(off);
  endfunction

  function automatic logic [7:0] defaultByte(input int key);
    return 8'(key) ^ 8'(key >> 8) ^ 8'h3C;
  endfunction

  function automatic logic [7:0] memRead(input int key);
    if (sram.exists(key)) return sram[key];
    return defaultByte(key);
  endfunction

  function automatic logic [7:0] refRead(input int key);
    if (refMem.exists(key)) return refMem[key];
    return defaultByte(key);
  endfunction

  function automatic int chipIdx(input logic [3:0] csn);
    case (csn)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  // SRAM model and bus-rule monitor, evaluated mid-cycle.
  always @(negedge clk) begin : sramModel
    int c;
    c = chipIdx(hr_cs_n);
    if (c >= 0 && !hr_oe_n) hr_din = memRead(keyOf(c, rbank, hr_adr));
    else hr_din = 8'hEE;
    if (c >= 0 && !hr_we_n) sram[keyOf(c, rbank, hr_adr)] = hr_dout;
    if (hr_cs_n != 4'hF && c < 0) viol++;
    if (hr_cs_n != 4'hF && !bus_dma) viol++;
    if (!hr_we_n && !hr_oe_n) viol++;
    if ((!hr_we_n || !hr_oe_n) && hr_cs_n == 4'hF) viol++;
    if (!bus_dma && rbank != cpu_bank[5:0]) viol++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic present(input req_t r);
    dma_req   = 1'b1;
    dma_we    = r.we;
    dma_bank  = r.bank;
    dma_addr  = r.addr;
    dma_wdata = r.data;
  endtask

  // Streams every queued request back-to-back, acting as a requester that
  // offers the next request in the ack cycle. Grants are expected to carry
  // MB accesses each until the queue runs dry, and the CPU must see a
  // cyc_end while running between a capped grant and the next halt.
  task automatic runStream();
    int grants[$];
    int expGrants[$];
    int curAcks;
    int cyc;
    int endsWhileRdy;
    int rem;
    int k;
    bit prevBus;
    bit prevRdy;
    bit limitPending;
    req_t head;
    curAcks = 0; cyc = 0; endsWhileRdy = 0; limitPending = 0;
    rem = q.size();
    while (rem > 0) begin
      expGrants.push_back(rem > MB ? MB : rem);
      rem -= (rem > MB ? MB : rem);
    end
    present(q[0]);
    prevBus = bus_dma;
    prevRdy = cpu_rdy;
    while ((q.size() > 0 || bus_dma) && cyc < 4000) begin
      cyc_end  = ($urandom_range(0, 2) == 0);
      cpu_bank = 8'($urandom);
      tick();
      cyc++;
      if (limitPending && prevRdy && !cpu_rdy) begin
        check("holdoff_cpu_cycle", 32'(endsWhileRdy > 0), 1);
        limitPending = 0;
      end
      if (cyc_end && prevRdy) endsWhileRdy++;
      if (!prevRdy && cpu_rdy) endsWhileRdy = 0;
      if (bus_dma && !prevBus) curAcks = 0;
      if (!bus_dma && prevBus) begin
        grants.push_back(curAcks);
        if (q.size() > 0) limitPending = (curAcks == MB);
      end
      if (dma_ack) begin
        if (q.size() == 0) begin
          check("spurious_ack", 1, 0);
        end else begin
          head = q.pop_front();
          curAcks++;
          k = keyOf(int'(head.bank[7:6]), head.bank[5:0], head.addr);
          if (head.we) refMem[k] = head.data;
          else check("stream_rdata", dma_rdata, refRead(k));
          if (q.size() > 0) present(q[0]);
          else dma_req = 1'b0;
        end
      end
      prevBus = bus_dma;
      prevRdy = cpu_rdy;
    end
    cyc_end = 1'b0;
    dma_req = 1'b0;
    check("stream_done", 32'(q.size() == 0 && !bus_dma), 1);
    q.delete();
    check("grant_count", grants.size(), expGrants.size());
    for (int i = 0; i < expGrants.size() && i < grants.size(); i++)
      check("grant_acks", grants[i], expGrants[i]);
    tick();
    tick();
    check("stream_rdy_back", cpu_rdy, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    req_t r;
    int acks;
    int weLow;
    int csSeen;
    bit flag;
    bit got;
    int k;

    rst = 1'b0; cyc_end = 1'b0; cpu_bank = 8'h3A; dma_req = 1'b0; dma_we = 1'b0;
    dma_bank = 8'h00; dma_addr = '0; dma_wdata = 8'h00;
    tick(); tick();
    check("rst_rdy", cpu_rdy, 1);
    check("rst_bus", bus_dma, 0);
    check("rst_gnt", dma_gnt, 0);
    check("rst_ack", dma_ack, 0);
    check("rst_rdata", dma_rdata, 8'h00);
    check("rst_cs", hr_cs_n, 4'hF);
    check("rst_we", hr_we_n, 1);
    check("rst_oe", hr_oe_n, 1);
    check("rst_rbank", rbank, 6'h3A);
    rst = 1'b1;
    tick();

    // Single read, cyc_end three clocks after the request.
    sram[keyOf(2, 6'h05, 13'h0123)] = 8'h5A;
    r.we = 1'b0; r.bank = 8'h85; r.addr = 13'h0123; r.data = 8'h00;
    present(r);
    tick();
    check("rd_rdy_low", cpu_rdy, 0);
    check("rd_bus_halt", bus_dma, 0);
    tick();
    tick();
    cyc_end = 1'b1;
    tick();
    cyc_end = 1'b0;
    check("rd_turn_bus", bus_dma, 1);
    check("rd_turn_gnt", dma_gnt, 1);
    check("rd_turn_cs", hr_cs_n, 4'hF);
    check("rd_rbank", rbank, 6'h05);
    for (int i = 0; i < ACC; i++) begin
      tick();
      check("rd_acc_cs", hr_cs_n, 4'b1011);
      check("rd_acc_oe", hr_oe_n, 0);
      check("rd_acc_we", hr_we_n, 1);
      check("rd_acc_adr", hr_adr, 13'h0123);
      check("rd_acc_ack", dma_ack, 0);
    end
    tick();
    check("rd_ack", dma_ack, 1);
    check("rd_rdata", dma_rdata, 8'h5A);
    check("rd_ack_oe", hr_oe_n, 1);
    dma_req = 1'b0;
    tick();
    check("rd_rel_ack", dma_ack, 0);
    check("rd_rel_bus", bus_dma, 0);
    check("rd_rel_rdy", cpu_rdy, 0);
    tick();
    check("rd_rdy_back", cpu_rdy, 1);
    check("rd_rdata_hold", dma_rdata, 8'h5A);

    // Single write to chip 3.
    r.we = 1'b1; r.bank = 8'hC0; r.addr = 13'h1ABC; r.data = 8'hA7;
    present(r);
    acks = 0; weLow = 0;
    tick();
    check("wr_rdy_low", cpu_rdy, 0);
    tick();
    cyc_end = 1'b1;
    tick();
    cyc_end = 1'b0;
    check("wr_turn_bus", bus_dma, 1);
    for (int i = 0; i < ACC; i++) begin
      tick();
      check("wr_acc_cs", hr_cs_n, 4'b0111);
      check("wr_acc_dout", hr_dout, 8'hA7);
      check("wr_acc_adr", hr_adr, 13'h1ABC);
      if (!hr_we_n) weLow++;
      if (dma_ack) acks++;
    end
    check("wr_last_we_high", hr_we_n, 1);
    tick();
    if (dma_ack) acks++;
    dma_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (dma_ack) acks++;
    end
    check("wr_we_low_clocks", weLow, ACC - 1);
    check("wr_ack_pulses", acks, 1);
    check("wr_sram", memRead(keyOf(3, 6'h00, 13'h1ABC)), 8'hA7);
    check("wr_rdy_back", cpu_rdy, 1);

    // Reset asserted in the middle of a write.
    r.we = 1'b1; r.bank = 8'h40; r.addr = 13'h0055; r.data = 8'h33;
    present(r);
    tick();
    tick();
    cyc_end = 1'b1;
    tick();
    cyc_end = 1'b0;
    tick();
    check("mrst_we_active", hr_we_n, 0);
    tick();
    rst = 1'b0;
    tick();
    check("mrst_we", hr_we_n, 1);
    check("mrst_cs", hr_cs_n, 4'hF);
    check("mrst_bus", bus_dma, 0);
    check("mrst_rdy", cpu_rdy, 1);
    check("mrst_ack", dma_ack, 0);
    tick();
    check("mrst_ack2", dma_ack, 0);
    rst = 1'b1;
    dma_req = 1'b0;
    tick();
    check("mrst_idle_bus", bus_dma, 0);
    check("mrst_idle_ack", dma_ack, 0);

    // Request raised together with cyc_end while idle.
    r.we = 1'b0; r.bank = 8'h07; r.addr = 13'h0777; r.data = 8'h00;
    present(r);
    cyc_end = 1'b1;
    tick();
    cyc_end = 1'b0;
    check("same_rdy_low", cpu_rdy, 0);
    flag = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus_dma) flag = 1'b1;
    end
    check("same_no_early_turn", flag, 0);
    cyc_end = 1'b1;
    tick();
    cyc_end = 1'b0;
    check("same_turn", bus_dma, 1);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (dma_ack) got = 1'b1;
    end
    check("same_ack_seen", got, 1);
    k = keyOf(0, 6'h07, 13'h0777);
    check("same_rdata", dma_rdata, refRead(k));
    dma_req = 1'b0;
    tick();
    tick();
    check("same_rdy_back", cpu_rdy, 1);

    // Request withdrawn while the CPU is being halted.
    r.we = 1'b1; r.bank = 8'h81; r.addr = 13'h0010; r.data = 8'h99;
    present(r);
    acks = 0; csSeen = 0;
    tick();
    dma_req = 1'b0;
    tick();
    cyc_end = 1'b1;
    tick();
    cyc_end = 1'b0;
    check("drop_turn_bus", bus_dma, 1);
    check("drop_turn_gnt", dma_gnt, 1);
    tick();
    if (hr_cs_n != 4'hF) csSeen++;
    if (dma_ack) acks++;
    check("drop_rel_bus", bus_dma, 0);
    check("drop_rel_rdy", cpu_rdy, 0);
    tick();
    if (hr_cs_n != 4'hF) csSeen++;
    if (dma_ack) acks++;
    check("drop_rdy_back", cpu_rdy, 1);
    tick();
    if (dma_ack) acks++;
    check("drop_no_ack", acks, 0);
    check("drop_no_access", csSeen, 0);

    // 20 continuous writes: one capped grant of MB, then the rest.
    for (int i = 0; i < 20; i++) begin
      r.we = 1'b1; r.bank = 8'($urandom); r.addr = 13'($urandom); r.data = 8'($urandom);
      q.push_back(r);
      wr.push_back(r);
    end
    runStream();
    foreach (wr[i]) begin
      k = keyOf(int'(wr[i].bank[7:6]), wr[i].bank[5:0], wr[i].addr);
      check("burst_sram", memRead(k), refRead(k));
    end

    // 20 continuous reads of the written locations.
    for (int i = 0; i < 20; i++) begin
      r = wr[$urandom_range(0, 19)];
      r.we = 1'b0;
      q.push_back(r);
    end
    runStream();

    // Mixed reads and writes over a small address set.
    for (int i = 0; i < 12; i++) begin
      r.we   = 1'($urandom);
      r.bank = {2'($urandom), 6'($urandom_range(0, 1))};
      r.addr = 13'($urandom_range(0, 7));
      r.data = 8'($urandom);
      q.push_back(r);
    end
    runStream();

    check("bus_rules", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
